// File: rtl/sfr_bitreg_bank.sv
// sfr_bitreg_bank: bank of NUM_REGS bit-addressable 8-bit SFRs for the 8051 core.
//
// Register i lives at byte address BASE_ADDR + 8*i. Core writes may be byte
// writes or bit writes. Per-register hardware loads take priority below
// software writes. The read path is registered, read-before-write.
//
// Optional build macro: SFR_TIMED_ACCESS_EN
//   Compiles in a timed-access unlock FSM (AAh, 55h to TA_ADDR) that guards
//   registers selected by LOCK_MASK. Without it, every register is freely
//   writable and ta_open / wr_denied are tied low.
//
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   addr          byte address, or bit address when wr_bit_en is set
//   data_in       byte write data
//   wr_en         write strobe
//   wr_bit_en     bit mode qualifier for both write and read
//   bit_in        bit write data
//   rd_en         read strobe
//   rd_data       registered read byte
//   rd_bit        registered read bit (bit mode only)
//   rd_hit        registered: last read decoded to this bank
//   hw_we         per-register hardware load enable
//   hw_data       per-register hardware load data, flat
//   regs          current register contents, flat
//   parity        per-register XOR of regs
//   ta_open       timed-access write window open
//   wr_denied     one-cycle pulse after a protected write was dropped
module sfr_bitreg_bank #(
    parameter int unsigned           NUM_REGS  = 4,
    parameter logic [7:0]            BASE_ADDR = 8'hE0,
    parameter logic [8*NUM_REGS-1:0] RESET_VAL = '0,
    parameter logic [NUM_REGS-1:0]   LOCK_MASK = '0,
    parameter logic [7:0]            TA_ADDR   = 8'hC7,
    parameter int unsigned           TA_WINDOW = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              addr,
    input  logic [7:0]              data_in,
    input  logic                    wr_en,
    input  logic                    wr_bit_en,
    input  logic                    bit_in,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    rd_bit,
    output logic                    rd_hit,
    input  logic [NUM_REGS-1:0]     hw_we,
    input  logic [8*NUM_REGS-1:0]   hw_data,
    output logic [8*NUM_REGS-1:0]   regs,
    output logic [NUM_REGS-1:0]     parity,
    output logic                    ta_open,
    output logic                    wr_denied
);

    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] byte_hit;
    logic [NUM_REGS-1:0] bit_hit;
    logic [NUM_REGS-1:0] any_hit;
    logic [NUM_REGS-1:0] wr_ok;

    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_bit_q, rd_bit_d;
    logic       rd_hit_q, rd_hit_d;

    // Address decode. Bit mode matches on addr[7:3]; addr[2:0] is the bit.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
        localparam logic [7:0] RegAddr = BASE_ADDR + 8'(8 * i);
        assign byte_hit[i] = !wr_bit_en && (addr == RegAddr);
        assign bit_hit[i]  = wr_bit_en && (addr[7:3] == RegAddr[7:3]);
    end
    assign any_hit = byte_hit | bit_hit;

`ifdef SFR_TIMED_ACCESS_EN
    localparam int unsigned CntW = $clog2(TA_WINDOW + 1);

    typedef enum logic [1:0] {StIdle, StArmed, StOpen} ta_state_e;

    ta_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          wr_denied_q, wr_denied_d;
    logic          key_wr;
    logic          locked_wr;
    logic          window_open;

    assign key_wr    = wr_en && !wr_bit_en && (addr == TA_ADDR);
    assign locked_wr = wr_en && |(any_hit & LOCK_MASK);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_denied_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_denied_q <= wr_denied_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (key_wr && data_in == 8'hAA) state_d = StArmed;
            end
            StArmed: begin
                // Any write other than the second key byte breaks the sequence.
                if (wr_en) begin
                    if (key_wr && data_in == 8'h55) begin
                        state_d = StOpen;
                        cnt_d   = CntW'(TA_WINDOW);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOpen: begin
                cnt_d = cnt_q - 1'b1;
                // The window is single-use: the first protected write closes it.
                if (locked_wr) begin
                    state_d = StIdle;
                end else if (key_wr && data_in == 8'hAA) begin
                    state_d = StArmed;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        window_open = (state_q == StOpen);
        wr_denied_d = locked_wr && !window_open;
        wr_ok       = wr_en ? (any_hit & (~LOCK_MASK | {NUM_REGS{window_open}})) : '0;
    end

    assign ta_open   = window_open;
    assign wr_denied = wr_denied_q;
`else
    logic unused_ta_cfg;
    assign unused_ta_cfg = ^{LOCK_MASK, TA_ADDR, TA_WINDOW};

    assign wr_ok     = wr_en ? any_hit : '0;
    assign ta_open   = 1'b0;
    assign wr_denied = 1'b0;
`endif

    // Next-state merge: hardware load first, software write layered on top.
    // A bit write keeps the other seven bits from the hardware load if present.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = hw_we[i] ? hw_data[8*i +: 8] : regs_q[i];
            if (wr_ok[i]) begin
                if (byte_hit[i]) begin
                    regs_d[i] = data_in;
                end else begin
                    regs_d[i][addr[2:0]] = bit_in;
                end
            end
        end
    end

    // Read mux sees the pre-write value so a same-cycle write is not visible.
    always_comb begin
        rd_data_d = '0;
        rd_bit_d  = 1'b0;
        rd_hit_d  = 1'b0;
        if (rd_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (any_hit[i]) begin
                    rd_hit_d  = 1'b1;
                    rd_data_d = regs_q[i];
                    rd_bit_d  = wr_bit_en & regs_q[i][addr[2:0]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[8*i +: 8];
            end
            rd_data_q <= '0;
            rd_bit_q  <= 1'b0;
            rd_hit_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_q <= rd_data_d;
            rd_bit_q  <= rd_bit_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs[8*i +: 8] = regs_q[i];
        assign parity[i]      = ^regs_q[i];
    end

    assign rd_data = rd_data_q;
    assign rd_bit  = rd_bit_q;
    assign rd_hit  = rd_hit_q;

endmodule

// File: tb/tb_sfr_bitreg_bank.sv
// Self-checking bench for sfr_bitreg_bank (4 registers at E0h..F8h, reg0 locked).
// Read expectations are queued from the bench's register model when rd_en is
// driven and compared one cycle later when the registered read appears.
module tb_sfr_bitreg_bank;

    localparam logic [31:0] ResetImg = {8'h07, 8'h00, 8'h80, 8'h00};

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic [7:0]  data_in;
    logic        wr_en;
    logic        wr_bit_en;
    logic        bit_in;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_bit;
    logic        rd_hit;
    logic [3:0]  hw_we;
    logic [31:0] hw_data;
    logic [31:0] regs;
    logic [3:0]  parity;
    logic        ta_open;
    logic        wr_denied;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       h;
    } rd_exp_t;

    rd_exp_t    sb[$];
    logic [7:0] mdl [4];
    int         errors = 0;
    int         checks = 0;

    always #5 clock = ~clock;

    sfr_bitreg_bank #(
        .NUM_REGS (4),
        .BASE_ADDR(8'hE0),
        .RESET_VAL(ResetImg),
        .LOCK_MASK(4'b0001),
        .TA_ADDR  (8'hC7),
        .TA_WINDOW(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .wr_bit_en(wr_bit_en),
        .bit_in   (bit_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_bit   (rd_bit),
        .rd_hit   (rd_hit),
        .hw_we    (hw_we),
        .hw_data  (hw_data),
        .regs     (regs),
        .parity   (parity),
        .ta_open  (ta_open),
        .wr_denied(wr_denied)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) mdl[i] = ResetImg[8*i +: 8];
    endtask

    task automatic check_regs(input string tag);
        check(tag, regs, {mdl[3], mdl[2], mdl[1], mdl[0]});
    endtask

    // Bench-side decode of the bank: E0h..FFh, byte mode needs addr[2:0] == 0.
    task automatic predict(output rd_exp_t e);
        logic [1:0] idx;
        e   = '0;
        idx = addr[4:3];
        if (addr >= 8'hE0) begin
            if (wr_bit_en) begin
                e.h = 1'b1;
                e.d = mdl[idx];
                e.b = mdl[idx][addr[2:0]];
            end else if (addr[2:0] == 3'd0) begin
                e.h = 1'b1;
                e.d = mdl[idx];
            end
        end
    endtask

    // One clock: queue read expectation, step, compare, then drop strobes.
    task automatic tick();
        rd_exp_t e;
        bit      issued;
        issued = rd_en;
        if (issued) begin
            predict(e);
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (issued) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_data, e.d);
                check("rd_bit", rd_bit, e.b);
                check("rd_hit", rd_hit, e.h);
            end
        end
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_bit_en = 1'b0;
        bit_in    = 1'b0;
        hw_we     = '0;
    endtask

    task automatic byte_wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; wr_en = 1'b1;
        tick();
    endtask

    task automatic bit_wr(input logic [7:0] a, input logic b);
        addr = a; bit_in = b; wr_en = 1'b1; wr_bit_en = 1'b1;
        tick();
    endtask

    task automatic rd_at(input logic [7:0] a, input logic bitmode);
        addr = a; rd_en = 1'b1; wr_bit_en = bitmode;
        tick();
    endtask

    task automatic unlock();
        byte_wr(8'hC7, 8'hAA);
        byte_wr(8'hC7, 8'h55);
    endtask

    initial begin
        reset = 1'b1; addr = '0; data_in = '0; wr_en = 1'b0; wr_bit_en = 1'b0;
        bit_in = 1'b0; rd_en = 1'b0; hw_we = '0; hw_data = '0;
        tick();
        tick();
        mdl_reset();
        check_regs("reset_regs");
        check("reset_parity", parity, 4'b1010);
        check("reset_rd_hit", rd_hit, 1'b0);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_ta_open", ta_open, 1'b0);
        check("reset_wr_denied", wr_denied, 1'b0);
        reset = 1'b0;

        // Byte write then bit write into reg1, then read it back.
        byte_wr(8'hE8, 8'h5A);
        mdl[1] = 8'h5A;
        bit_wr(8'hEF, 1'b1);
        mdl[1] = 8'hDA;
        check("reg1_bitwr", regs[15:8], 8'hDA);
        check("parity1", parity[1], 1'b1);
        rd_at(8'hE8, 1'b0);

        // Hardware load and bit clear in the same cycle on reg2.
        hw_we = 4'b0100; hw_data = 32'h00FF_0000;
        addr = 8'hF3; bit_in = 1'b0; wr_en = 1'b1; wr_bit_en = 1'b1;
        tick();
        mdl[2] = 8'hF7;
        check("reg2_hw_bit", regs[23:16], 8'hF7);

        // Read-before-write on reg0.
        unlock();
        addr = 8'hE0; data_in = 8'h11; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        mdl[0] = 8'h11;
        check("reg0_rbw", regs[7:0], 8'h11);

        // Miss read, then bit reads.
        rd_at(8'h90, 1'b0);
        unlock();
        byte_wr(8'hE0, 8'h20);
        mdl[0] = 8'h20;
        rd_at(8'hE5, 1'b1);
        rd_at(8'hE4, 1'b1);
        rd_at(8'hFA, 1'b1);

        // Writes outside the bank (including unaligned byte address) are ignored.
        byte_wr(8'h90, 8'hFF);
        bit_wr(8'h88, 1'b1);
        byte_wr(8'hE1, 8'hFF);
        check_regs("outside_regs");
        check("outside_denied", wr_denied, 1'b0);

`ifdef SFR_TIMED_ACCESS_EN
        // Locked write without the key is dropped; pulse lasts one cycle.
        byte_wr(8'hE0, 8'h33);
        check("locked_drop", regs[7:0], 8'h20);
        check("denied_pulse", wr_denied, 1'b1);
        tick();
        check("denied_one_cycle", wr_denied, 1'b0);

        // Key sequence opens window; first locked write closes it.
        unlock();
        check("ta_open_after_key", ta_open, 1'b1);
        byte_wr(8'hE0, 8'h33);
        mdl[0] = 8'h33;
        check("locked_ok", regs[7:0], 8'h33);
        check("ta_closed_after_wr", ta_open, 1'b0);
        check("ok_not_denied", wr_denied, 1'b0);

        // Window expires after TA_WINDOW cycles.
        unlock();
        tick(); tick(); tick();
        check("ta_open_last_cycle", ta_open, 1'b1);
        tick();
        check("ta_expired", ta_open, 1'b0);
        tick();
        byte_wr(8'hE0, 8'h44);
        check("late_wr_drop", regs[7:0], 8'h33);
        check("late_wr_denied", wr_denied, 1'b1);

        // An intervening write breaks the key sequence; unlocked writes still work.
        byte_wr(8'hC7, 8'hAA);
        byte_wr(8'hE8, 8'h12);
        mdl[1] = 8'h12;
        check("unlocked_wr", regs[15:8], 8'h12);
        byte_wr(8'hC7, 8'h55);
        check("broken_seq_closed", ta_open, 1'b0);
        byte_wr(8'hE0, 8'h66);
        check("broken_seq_denied", wr_denied, 1'b1);
        check_regs("broken_seq_regs");

        // Reset during an open window.
        unlock();
        check("ta_open_pre_reset", ta_open, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_reset();
        check("ta_reset_closed", ta_open, 1'b0);
        check_regs("reset2_regs");
`else
        // Without timed access every register is writable and nothing is flagged.
        byte_wr(8'hE0, 8'h33);
        mdl[0] = 8'h33;
        check("free_wr", regs[7:0], 8'h33);
        check("free_not_denied", wr_denied, 1'b0);
        unlock();
        check("ta_tied_low", ta_open, 1'b0);
        check_regs("final_regs");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
